// File: rtl/mac_accum_pipe_if.sv
// Beat-in / result-out bundle for mac_accum_pipe; the master drives beats, the slave (the MAC) returns results.
interface mac_accum_pipe_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              first;
    logic              last;
    logic              clr;
    logic [ACC_W-1:0]  acc_out;
    logic              out_valid;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output in_valid, a, b, first, last, clr,
        input  acc_out, out_valid, count, overflow
    );

    modport slave (
        input  in_valid, a, b, first, last, clr,
        output acc_out, out_valid, count, overflow
    );
endinterface

// File: rtl/mac_accum_pipe.sv
// Two-stage unsigned multiply-accumulate over first/last framed vectors.
// Define MAC_ACCUM_SAT_EN to clamp the accumulator on carry-out instead of wrapping.
module mac_accum_pipe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input logic              clk,
    input logic              rst,
    mac_accum_pipe_if.slave  bus
);

    localparam int PROD_W = 2 * DATA_W;

`ifdef MAC_ACCUM_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    generate
        if (ACC_W < PROD_W) begin : g_acc_w_check
            $error("mac_accum_pipe: ACC_W must be at least 2*DATA_W");
        end
    endgenerate

    function automatic logic [ACC_W-1:0] acc_limit(input logic carry, input logic [ACC_W-1:0] low);
        return (carry && SAT_EN) ? {ACC_W{1'b1}} : low;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod_p1_q;
    logic              vld_p1_q;
    logic              first_p1_q;
    logic              last_p1_q;

    logic [ACC_W-1:0]  acc_p2_q, acc_p2_d;
    logic [CNT_W-1:0]  cnt_p2_q, cnt_p2_d;
    logic              ovf_p2_q, ovf_p2_d;
    logic              vld_p2_q, vld_p2_d;
    logic [ACC_W:0]    sum_p2;

    assign a_ext = PROD_W'(bus.a);
    assign b_ext = PROD_W'(bus.b);

    // Stage 1: register full-width product with its framing bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_p1_q  <= '0;
            vld_p1_q   <= 1'b0;
            first_p1_q <= 1'b0;
            last_p1_q  <= 1'b0;
        end else begin
            prod_p1_q  <= a_ext * b_ext;
            vld_p1_q   <= bus.in_valid & ~bus.clr;
            first_p1_q <= bus.first & ~bus.clr;
            last_p1_q  <= bus.last & ~bus.clr;
        end
    end

    // Stage 2: accumulate, count beats, track carry-out
    always_comb begin
        sum_p2   = (ACC_W+1)'(acc_p2_q) + (ACC_W+1)'(prod_p1_q);
        acc_p2_d = acc_p2_q;
        cnt_p2_d = cnt_p2_q;
        ovf_p2_d = ovf_p2_q;
        vld_p2_d = 1'b0;
        if (bus.clr) begin
            acc_p2_d = '0;
            cnt_p2_d = '0;
            ovf_p2_d = 1'b0;
        end else if (vld_p1_q) begin
            vld_p2_d = last_p1_q;
            if (first_p1_q) begin
                acc_p2_d = ACC_W'(prod_p1_q);
                cnt_p2_d = CNT_W'(1);
                ovf_p2_d = 1'b0;
            end else begin
                acc_p2_d = acc_limit(sum_p2[ACC_W], sum_p2[ACC_W-1:0]);
                cnt_p2_d = cnt_inc(cnt_p2_q);
                ovf_p2_d = ovf_p2_q | sum_p2[ACC_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p2_q <= '0;
            cnt_p2_q <= '0;
            ovf_p2_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            acc_p2_q <= acc_p2_d;
            cnt_p2_q <= cnt_p2_d;
            ovf_p2_q <= ovf_p2_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    assign bus.acc_out   = acc_p2_q;
    assign bus.count     = cnt_p2_q;
    assign bus.overflow  = ovf_p2_q;
    assign bus.out_valid = vld_p2_q;

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Drives a default MAC (ACC_W=40, CNT_W=8) and a narrow one (ACC_W=32, CNT_W=2) with identical beats
// and compares both against a vector-level arithmetic model.
module tb_mac_accum_pipe;

`ifdef MAC_ACCUM_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        iv, fst, lst, clr_r;
    logic [15:0] av, bv;

    int n_checks = 0;
    int n_fail   = 0;

    mac_accum_pipe_if #(.DATA_W(16), .ACC_W(40), .CNT_W(8)) bus_a ();
    mac_accum_pipe_if #(.DATA_W(16), .ACC_W(32), .CNT_W(2)) bus_b ();

    assign bus_a.in_valid = iv;
    assign bus_a.a        = av;
    assign bus_a.b        = bv;
    assign bus_a.first    = fst;
    assign bus_a.last     = lst;
    assign bus_a.clr      = clr_r;
    assign bus_b.in_valid = iv;
    assign bus_b.a        = av;
    assign bus_b.b        = bv;
    assign bus_b.first    = fst;
    assign bus_b.last     = lst;
    assign bus_b.clr      = clr_r;

    mac_accum_pipe #(.DATA_W(16), .ACC_W(40), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mac_accum_pipe #(.DATA_W(16), .ACC_W(32), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: each sampled beat joins the vector one cycle later
    typedef struct {
        longint unsigned p;
        bit              f;
        bit              l;
    } beat_t;

    beat_t           inflight[$];
    int              accw[2] = '{40, 32};
    int              cntw[2] = '{8, 2};
    longint unsigned m_acc[2];
    longint unsigned m_cnt[2];
    bit              m_ovf[2];
    bit              m_ov[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_ov[k] = 0;
        end
        inflight.delete();
    endtask

    task automatic model_apply(input int k, input beat_t bt);
        longint unsigned lim, s, cmax;
        lim  = 64'd1 << accw[k];
        cmax = (64'd1 << cntw[k]) - 1;
        if (bt.f) begin
            m_acc[k] = bt.p;
            m_cnt[k] = 1;
            m_ovf[k] = 0;
        end else begin
            s = m_acc[k] + bt.p;
            if (s >= lim) begin
                m_ovf[k] = 1;
                m_acc[k] = SAT_EN ? lim - 1 : s - lim;
            end else begin
                m_acc[k] = s;
            end
            m_cnt[k] = (m_cnt[k] < cmax) ? m_cnt[k] + 1 : cmax;
        end
        m_ov[k] = bt.l;
    endtask

    task automatic model_edge();
        beat_t bt;
        if (clr_r) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) m_ov[k] = 0;
            if (inflight.size() != 0) begin
                bt = inflight.pop_front();
                for (int k = 0; k < 2; k++) model_apply(k, bt);
            end
            if (iv) begin
                bt.p = 64'(av) * 64'(bv);
                bt.f = fst;
                bt.l = lst;
                inflight.push_back(bt);
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("acc_a",  64'(bus_a.acc_out),   m_acc[0]);
        check("cnt_a",  64'(bus_a.count),     m_cnt[0]);
        check("ovf_a",  64'(bus_a.overflow),  64'(m_ovf[0]));
        check("vld_a",  64'(bus_a.out_valid), 64'(m_ov[0]));
        check("acc_b",  64'(bus_b.acc_out),   m_acc[1]);
        check("cnt_b",  64'(bus_b.count),     m_cnt[1]);
        check("ovf_b",  64'(bus_b.overflow),  64'(m_ovf[1]));
        check("vld_b",  64'(bus_b.out_valid), 64'(m_ov[1]));
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic beat(input bit v, input logic [15:0] ai, input logic [15:0] bi,
                        input bit f, input bit l, input bit c);
        iv = v; av = ai; bv = bi; fst = f; lst = l; clr_r = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle();
        beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        iv = 0; av = 0; bv = 0; fst = 0; lst = 0; clr_r = 0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Three-beat vector
        beat(1, 16'd5, 16'd6, 1, 0, 0);
        beat(1, 16'd2, 16'd3, 0, 0, 0);
        check("r033_acc1", 64'(bus_a.acc_out), 64'h1E);
        beat(1, 16'd8, 16'd9, 0, 1, 0);
        check("r033_acc2", 64'(bus_a.acc_out), 64'h24);
        idle();
        check("r033_acc3", 64'(bus_a.acc_out), 64'h6C);
        check("r033_vld",  64'(bus_a.out_valid), 64'd1);
        check("r033_cnt",  64'(bus_a.count), 64'd3);
        idle();
        check("r033_vld_off", 64'(bus_a.out_valid), 64'd0);

        // Single-beat vector directly followed by a two-beat vector
        beat(1, 16'd7, 16'd7, 1, 1, 0);
        beat(1, 16'd1, 16'd1, 1, 0, 0);
        check("r034_vld1", 64'(bus_a.out_valid), 64'd1);
        check("r034_acc1", 64'(bus_a.acc_out), 64'h31);
        beat(1, 16'd1, 16'd1, 0, 1, 0);
        check("r034_gap", 64'(bus_a.out_valid), 64'd0);
        idle();
        check("r034_vld2", 64'(bus_a.out_valid), 64'd1);
        check("r034_acc2", 64'(bus_a.acc_out), 64'h2);

        // Carry-out of the 32-bit accumulator
        beat(1, 16'hFFFF, 16'hFFFF, 1, 0, 0);
        beat(1, 16'hFFFF, 16'hFFFF, 0, 1, 0);
        idle();
        check("r035_acc_b", 64'(bus_b.acc_out), SAT_EN ? 64'hFFFF_FFFF : 64'hFFFC_0002);
        check("r035_ovf_b", 64'(bus_b.overflow), 64'd1);
        check("r035_acc_a", 64'(bus_a.acc_out), 64'h1_FFFC_0002);
        beat(1, 16'd1, 16'd1, 1, 1, 0);
        idle();
        check("r035_ovf_clr", 64'(bus_b.overflow), 64'd0);

        // clr wins over a beat on the same edge
        beat(1, 16'd3, 16'd4, 1, 0, 0);
        beat(1, 16'd3, 16'd4, 0, 0, 0);
        beat(1, 16'd3, 16'd4, 0, 0, 1);
        check("r036_acc0", 64'(bus_a.acc_out), 64'd0);
        check("r036_cnt0", 64'(bus_a.count), 64'd0);
        beat(1, 16'd2, 16'd2, 0, 1, 0);
        idle();
        check("r036_acc", 64'(bus_a.acc_out), 64'd4);
        check("r036_vld", 64'(bus_a.out_valid), 64'd1);

        // Asynchronous reset mid-vector
        beat(1, 16'd3, 16'd3, 1, 0, 0);
        beat(1, 16'd3, 16'd3, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("r037_async_acc", 64'(bus_a.acc_out), 64'd0);
        iv = 0; fst = 0; lst = 0; clr_r = 0;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        beat(1, 16'd1, 16'd2, 1, 1, 0);
        idle();
        check("r037_acc", 64'(bus_a.acc_out), 64'd2);
        check("r037_cnt", 64'(bus_a.count), 64'd1);
        check("r037_vld", 64'(bus_a.out_valid), 64'd1);

        // Count saturation on the 2-bit counter
        beat(1, 16'd1, 16'd1, 1, 0, 0);
        repeat (3) beat(1, 16'd1, 16'd1, 0, 0, 0);
        beat(1, 16'd1, 16'd1, 0, 1, 0);
        idle();
        check("r038_cnt_b", 64'(bus_b.count), 64'd3);
        check("r038_acc_b", 64'(bus_b.acc_out), 64'd5);
        check("r038_cnt_a", 64'(bus_a.count), 64'd5);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            beat(($urandom_range(0, 3) != 0), ra, rb,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 39) == 0));
        end
        repeat (3) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
